// File: rtl/cnn_result_wb_pkg.sv
// cnn_result_wb_pkg -- shared constants and types for the CNN result write-back block.
//   CNN_DATA_WIDTH  : ICB data/address width
//   CNN_ITAG_WIDTH  : EAI instruction tag width
//   CNN_ELEM_NUM    : number of 16-bit conv results (5x5 output)
//   CNN_WORD_NUM    : 32-bit words needed to hold CNN_ELEM_NUM halfwords
//   CNN_OUTS_MAX    : maximum outstanding ICB write commands
package cnn_result_wb_pkg;

  localparam int unsigned CNN_DATA_WIDTH = 32;
  localparam int unsigned CNN_ITAG_WIDTH = 2;
  localparam int unsigned CNN_ELEM_NUM   = 25;
  localparam int unsigned CNN_WORD_NUM   = 13;
  localparam int unsigned CNN_OUTS_MAX   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RESP  = 2'd2
  } wb_state_e;

  // Two halfwords per word; an odd element count leaves a half-filled last word.
  function automatic int unsigned word_count(input int unsigned elems);
    return (elems + 1) / 2;
  endfunction

endpackage

// File: rtl/cnn_result_wb_if.sv
// cnn_result_wb_if -- ICB command/response channel between the write-back block
// (master) and the memory port (slave). rdata is not carried: the block only writes.
//   cmd : valid/ready, addr, read, wdata, wmask[3:0]
//   rsp : valid/ready, err
interface cnn_result_wb_if
  import cnn_result_wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CNN_DATA_WIDTH
);
  logic                  eai_icb_cmd_valid;
  logic                  eai_icb_cmd_ready;
  logic [DATA_WIDTH-1:0] eai_icb_cmd_addr;
  logic                  eai_icb_cmd_read;
  logic [DATA_WIDTH-1:0] eai_icb_cmd_wdata;
  logic [3:0]            eai_icb_cmd_wmask;
  logic                  eai_icb_rsp_valid;
  logic                  eai_icb_rsp_ready;
  logic                  eai_icb_rsp_err;

  modport master (
    output eai_icb_cmd_valid, eai_icb_cmd_addr, eai_icb_cmd_read,
           eai_icb_cmd_wdata, eai_icb_cmd_wmask, eai_icb_rsp_ready,
    input  eai_icb_cmd_ready, eai_icb_rsp_valid, eai_icb_rsp_err
  );

  modport slave (
    input  eai_icb_cmd_valid, eai_icb_cmd_addr, eai_icb_cmd_read,
           eai_icb_cmd_wdata, eai_icb_cmd_wmask, eai_icb_rsp_ready,
    output eai_icb_cmd_ready, eai_icb_rsp_valid, eai_icb_rsp_err
  );
endinterface

// File: rtl/cnn_wb_pack.sv
// cnn_wb_pack -- combinational word packer.
//   res_y_i : packed results, element n at [16n+15:16n]
//   k_i     : word index
//   wdata_o : {elem 2k+1, elem 2k}; upper half zero when elem 2k+1 does not exist
//   wmask_o : 4'b1111 for a full word, 4'b0011 for the trailing half word
module cnn_wb_pack
  import cnn_result_wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int unsigned ELEM_NUM   = CNN_ELEM_NUM,
  parameter int unsigned CNT_W      = 4
) (
  input  logic [ELEM_NUM*16-1:0] res_y_i,
  input  logic [CNT_W-1:0]       k_i,
  output logic [DATA_WIDTH-1:0]  wdata_o,
  output logic [3:0]             wmask_o
);
  logic [15:0] lo;
  logic [15:0] hi;
  logic        hi_present;

  always_comb begin
    lo         = '0;
    hi         = '0;
    hi_present = 1'b0;
    for (int unsigned n = 0; n < ELEM_NUM; n++) begin
      if (n == 2 * 32'(k_i)) lo = res_y_i[n*16 +: 16];
      if (n == 2 * 32'(k_i) + 1) begin
        hi         = res_y_i[n*16 +: 16];
        hi_present = 1'b1;
      end
    end
    wdata_o = DATA_WIDTH'({hi, lo});
    wmask_o = hi_present ? 4'b1111 : 4'b0011;
  end
endmodule

// File: rtl/cnn_result_wb.sv
// cnn_result_wb -- writes a captured CNN result vector to memory over ICB as a
// burst of word writes, then reports completion to the core over EAI.
//   clk, rst        : single clock, synchronous active-high reset
//   res_*           : result request (valid/ready, packed results, base address, tag)
//   icb             : ICB master channel (write commands, responses)
//   eai_rsp_*       : completion to core (valid/ready, wdat=base address, itag, err)
//   eai_mem_holdup  : high while the block owns the memory port (WRITE state)
module cnn_result_wb
  import cnn_result_wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = CNN_DATA_WIDTH,
  parameter int unsigned DISP_ITAG_WIDTH = CNN_ITAG_WIDTH,
  parameter int unsigned ELEM_NUM        = CNN_ELEM_NUM,
  parameter int unsigned OUTS_MAX        = CNN_OUTS_MAX
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [ELEM_NUM*16-1:0]     res_y,
  input  logic [DATA_WIDTH-1:0]      res_addr,
  input  logic [DISP_ITAG_WIDTH-1:0] res_itag,
  cnn_result_wb_if.master            icb,
  output logic                       eai_rsp_valid,
  input  logic                       eai_rsp_ready,
  output logic [DATA_WIDTH-1:0]      eai_rsp_wdat,
  output logic [DISP_ITAG_WIDTH-1:0] eai_rsp_itag,
  output logic                       eai_rsp_err,
  output logic                       eai_mem_holdup
);
  localparam int unsigned      WORDS    = word_count(ELEM_NUM);
  localparam int unsigned      CNT_W    = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] OUTS_LIM = CNT_W'(OUTS_MAX);

  wb_state_e                  state_q, state_d;
  logic [ELEM_NUM*16-1:0]     y_q, y_d;
  logic [DATA_WIDTH-1:0]      addr_q, addr_d;
  logic [DISP_ITAG_WIDTH-1:0] itag_q, itag_d;
  logic                       err_q, err_d;
  logic [CNT_W-1:0]           cmd_cnt_q, cmd_cnt_d;
  logic [CNT_W-1:0]           rsp_cnt_q, rsp_cnt_d;
  logic                       cmd_valid;
  logic                       rsp_fire;

  // Command fields depend only on registered state, so they hold while stalled.
  cnn_wb_pack #(
    .DATA_WIDTH (DATA_WIDTH),
    .ELEM_NUM   (ELEM_NUM),
    .CNT_W      (CNT_W)
  ) u_pack (
    .res_y_i (y_q),
    .k_i     (cmd_cnt_q),
    .wdata_o (icb.eai_icb_cmd_wdata),
    .wmask_o (icb.eai_icb_cmd_wmask)
  );

  assign icb.eai_icb_cmd_valid = cmd_valid;
  assign icb.eai_icb_cmd_read  = 1'b0;
  assign icb.eai_icb_cmd_addr  = addr_q + (DATA_WIDTH'(cmd_cnt_q) << 2);
  assign icb.eai_icb_rsp_ready = ~rst;
  assign rsp_fire              = icb.eai_icb_rsp_valid & icb.eai_icb_rsp_ready;

  assign eai_rsp_wdat = (state_q == ST_RESP) ? addr_q : '0;
  assign eai_rsp_itag = (state_q == ST_RESP) ? itag_q : '0;
  assign eai_rsp_err  = (state_q == ST_RESP) ? err_q  : 1'b0;

  always_comb begin
    state_d        = state_q;
    y_d            = y_q;
    addr_d         = addr_q;
    itag_d         = itag_q;
    err_d          = err_q;
    cmd_cnt_d      = cmd_cnt_q;
    rsp_cnt_d      = rsp_cnt_q;
    res_ready      = 1'b0;
    cmd_valid      = 1'b0;
    eai_rsp_valid  = 1'b0;
    eai_mem_holdup = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        res_ready = 1'b1;
        if (res_valid) begin
          y_d    = res_y;
          addr_d = res_addr;
          itag_d = res_itag;
          // Misaligned base: skip the memory phase and report an error.
          if (res_addr[1:0] == 2'b00) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        eai_mem_holdup = 1'b1;
        cmd_valid = (cmd_cnt_q < LAST_CNT) && ((cmd_cnt_q - rsp_cnt_q) < OUTS_LIM);
        if (cmd_valid && icb.eai_icb_cmd_ready) cmd_cnt_d = cmd_cnt_q + 1'b1;
        // Responses outside WRITE (stale after reset) are accepted and ignored.
        if (rsp_fire) begin
          rsp_cnt_d = rsp_cnt_q + 1'b1;
          if (icb.eai_icb_rsp_err) err_d = 1'b1;
          if (rsp_cnt_q == LAST_CNT - 1'b1) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        eai_rsp_valid = 1'b1;
        if (eai_rsp_ready) begin
          state_d   = ST_IDLE;
          err_d     = 1'b0;
          cmd_cnt_d = '0;
          rsp_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      y_q       <= '0;
      addr_q    <= '0;
      itag_q    <= '0;
      err_q     <= 1'b0;
      cmd_cnt_q <= '0;
      rsp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      itag_q    <= itag_d;
      err_q     <= err_d;
      cmd_cnt_q <= cmd_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
    end
  end
endmodule

// File: tb/tb_cnn_result_wb.sv
// tb_cnn_result_wb -- self-checking bench for cnn_result_wb: a memory-side bus
// model records every accepted write and returns responses after a set delay;
// each scenario task compares the recorded traffic with words computed from the
// result elements and base address.
module tb_cnn_result_wb;
  import cnn_result_wb_pkg::*;

  localparam int unsigned DW = CNN_DATA_WIDTH;
  localparam int unsigned IW = CNN_ITAG_WIDTH;
  localparam int unsigned EN = CNN_ELEM_NUM;
  localparam int          NW = CNN_WORD_NUM;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          res_valid, res_ready;
  logic [EN*16-1:0] res_y;
  logic [DW-1:0] res_addr;
  logic [IW-1:0] res_itag;
  logic          eai_rsp_valid, eai_rsp_ready, eai_rsp_err, eai_mem_holdup;
  logic [DW-1:0] eai_rsp_wdat;
  logic [IW-1:0] eai_rsp_itag;

  cnn_result_wb_if #(.DATA_WIDTH(DW)) icb ();

  cnn_result_wb #(
    .DATA_WIDTH(DW), .DISP_ITAG_WIDTH(IW), .ELEM_NUM(EN), .OUTS_MAX(2)
  ) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
    .res_addr(res_addr), .res_itag(res_itag),
    .icb(icb),
    .eai_rsp_valid(eai_rsp_valid), .eai_rsp_ready(eai_rsp_ready),
    .eai_rsp_wdat(eai_rsp_wdat), .eai_rsp_itag(eai_rsp_itag),
    .eai_rsp_err(eai_rsp_err), .eai_mem_holdup(eai_mem_holdup)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc_no; logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask; } cmd_t;
  typedef struct { int due; logic err; } pend_t;
  typedef struct { int cyc_no; logic [31:0] wdat; logic [IW-1:0] itag; logic err; } eai_t;

  cmd_t  cmd_log[$];
  pend_t pend[$];
  eai_t  eai_log[$];
  int cfg_delay = 1, cfg_rdy_mode = 0, cfg_err_word = -1;
  int max_pend = 0, stall_changes = 0, holdup_cnt = 0, cmdv_cnt = 0, read_seen = 0, eai_unstable = 0;
  logic [15:0] el [EN];

  // Memory-side bus model and monitors; every decision is made at the negedge
  // for the following rising edge.
  initial begin
    logic        prev_stalled, eprev_stalled;
    logic [68:0] prev_fields;
    logic [DW+IW+1:0] eprev;
    prev_stalled = 1'b0; eprev_stalled = 1'b0; prev_fields = '0; eprev = '0;
    icb.eai_icb_cmd_ready = 1'b0; icb.eai_icb_rsp_valid = 1'b0; icb.eai_icb_rsp_err = 1'b0;
    forever begin
      @(negedge clk);
      case (cfg_rdy_mode)
        0:       icb.eai_icb_cmd_ready = 1'b1;
        1:       icb.eai_icb_cmd_ready = ~icb.eai_icb_cmd_ready;
        default: icb.eai_icb_cmd_ready = 1'($urandom_range(0, 1));
      endcase
      if (prev_stalled && {icb.eai_icb_cmd_valid, icb.eai_icb_cmd_addr, icb.eai_icb_cmd_wdata,
                           icb.eai_icb_cmd_wmask} !== prev_fields) stall_changes++;
      prev_stalled = icb.eai_icb_cmd_valid && !icb.eai_icb_cmd_ready;
      prev_fields  = {icb.eai_icb_cmd_valid, icb.eai_icb_cmd_addr, icb.eai_icb_cmd_wdata,
                      icb.eai_icb_cmd_wmask};
      if (icb.eai_icb_cmd_valid) cmdv_cnt++;
      if (icb.eai_icb_cmd_valid && icb.eai_icb_cmd_read) read_seen++;
      if (icb.eai_icb_cmd_valid && icb.eai_icb_cmd_ready) begin
        cmd_log.push_back('{cyc + 1, icb.eai_icb_cmd_addr, icb.eai_icb_cmd_wdata, icb.eai_icb_cmd_wmask});
        pend.push_back('{cyc + 1 + cfg_delay, (cmd_log.size() - 1 == cfg_err_word)});
      end
      if (pend.size() > max_pend) max_pend = pend.size();
      if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        icb.eai_icb_rsp_valid = 1'b1;
        icb.eai_icb_rsp_err   = pend[0].err;
        void'(pend.pop_front());
      end else begin
        icb.eai_icb_rsp_valid = 1'b0;
        icb.eai_icb_rsp_err   = 1'b0;
      end
      if (eai_mem_holdup) holdup_cnt++;
      if (eprev_stalled && {eai_rsp_valid, eai_rsp_wdat, eai_rsp_itag, eai_rsp_err} !== eprev) eai_unstable++;
      eprev_stalled = eai_rsp_valid && !eai_rsp_ready;
      eprev = {eai_rsp_valid, eai_rsp_wdat, eai_rsp_itag, eai_rsp_err};
      if (eai_rsp_valid && eai_rsp_ready) eai_log.push_back('{cyc + 1, eai_rsp_wdat, eai_rsp_itag, eai_rsp_err});
    end
  end

  // Reference: word k holds elements 2k (low) and 2k+1 (high) at base+4k.
  function automatic logic [67:0] exp_word(input logic [31:0] base, input int k);
    logic [15:0] lo, hi;
    logic [3:0]  m;
    lo = el[2*k];
    hi = 16'h0;
    m  = 4'b0011;
    if (2*k + 1 < EN) begin
      hi = el[2*k+1];
      m  = 4'b1111;
    end
    return {base + 32'(4*k), hi, lo, m};
  endfunction

  task automatic fill_elems(input bit ramp);
    for (int n = 0; n < EN; n++) el[n] = ramp ? 16'(n + 1) : 16'($urandom);
  endtask

  task automatic start_txn(input logic [31:0] a, input logic [IW-1:0] tag, input int dly,
                           input int mode, input int errw, output int t, output bit ok);
    cmd_log.delete(); eai_log.delete();
    max_pend = 0; stall_changes = 0; holdup_cnt = 0; cmdv_cnt = 0; read_seen = 0; eai_unstable = 0;
    cfg_delay = dly; cfg_rdy_mode = mode; cfg_err_word = errw;
    for (int n = 0; n < EN; n++) res_y[n*16 +: 16] = el[n];
    res_addr = a; res_itag = tag; res_valid = 1'b1;
    ok = 1'b0; t = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (res_ready) begin ok = 1'b1; t = cyc + 1; end
      @(posedge clk); #1;
    end
    res_valid = 1'b0;
  endtask

  task automatic wait_eai(output bit got);
    for (int i = 0; i < 400 && eai_log.size() == 0; i++) @(negedge clk);
    got = eai_log.size() > 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (icb.eai_icb_rsp_ready !== 1'b0) begin miscompares++;
      $display("FAIL rst_rsp_ready_in_reset: got %b want 0", icb.eai_icb_rsp_ready); end
    rst = 1'b0;
    #1;
    vectors++; if ({res_ready, icb.eai_icb_cmd_valid, icb.eai_icb_rsp_ready, icb.eai_icb_cmd_read} !== 4'b1010) begin
      miscompares++; $display("FAIL rst_handshake: got %b want 1010",
        {res_ready, icb.eai_icb_cmd_valid, icb.eai_icb_rsp_ready, icb.eai_icb_cmd_read}); end
    vectors++; if ({eai_rsp_valid, eai_rsp_err, eai_mem_holdup} !== 3'b000) begin miscompares++;
      $display("FAIL rst_eai_flags: got %b want 000", {eai_rsp_valid, eai_rsp_err, eai_mem_holdup}); end
    vectors++; if ({eai_rsp_wdat, eai_rsp_itag} !== '0) begin miscompares++;
      $display("FAIL rst_eai_fields: got %h/%h want 0/0", eai_rsp_wdat, eai_rsp_itag); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int t; bit ok, got;
    logic [67:0] w;
    fill_elems(1'b1);
    start_txn(32'h1000, 2'd2, 1, 0, -1, t, ok);
    wait_eai(got);
    vectors++; if ({ok, got} !== 2'b11) begin miscompares++; $display("FAIL basic_done: got %b want 11", {ok, got}); end
    vectors++; if (cmd_log.size() !== NW) begin miscompares++; $display("FAIL basic_nwrites: got %0d want %0d", cmd_log.size(), NW); end
    for (int k = 0; k < NW; k++) begin
      w = (k < cmd_log.size()) ? {cmd_log[k].addr, cmd_log[k].wdata, cmd_log[k].mask} : 'x;
      vectors++; if (w !== exp_word(32'h1000, k)) begin miscompares++;
        $display("FAIL basic_word%0d: got %h want %h", k, w, exp_word(32'h1000, k)); end
    end
    if (cmd_log.size() == NW) begin
      vectors++; if (cmd_log[0].wdata !== 32'h00020001) begin miscompares++;
        $display("FAIL basic_word0_const: got %h want 00020001", cmd_log[0].wdata); end
      vectors++; if ({cmd_log[12].addr, cmd_log[12].wdata, cmd_log[12].mask} !== {32'h1030, 32'h19, 4'b0011}) begin
        miscompares++; $display("FAIL basic_word12_const: got %h/%h/%b want 1030/00000019/0011",
          cmd_log[12].addr, cmd_log[12].wdata, cmd_log[12].mask); end
      vectors++; if ({cmd_log[0].cyc_no - t, cmd_log[12].cyc_no - t} !== {32'd1, 32'd13}) begin miscompares++;
        $display("FAIL basic_cmd_latency: got %0d,%0d want 1,13", cmd_log[0].cyc_no - t, cmd_log[12].cyc_no - t); end
    end
    if (got) begin
      vectors++; if (eai_log[0].cyc_no - t !== 15) begin miscompares++;
        $display("FAIL basic_eai_latency: got %0d want 15", eai_log[0].cyc_no - t); end
      vectors++; if ({eai_log[0].wdat, eai_log[0].itag, eai_log[0].err} !== {32'h1000, 2'd2, 1'b0}) begin miscompares++;
        $display("FAIL basic_eai_fields: got %h/%0d/%b want 00001000/2/0", eai_log[0].wdat, eai_log[0].itag, eai_log[0].err); end
    end
    vectors++; if (holdup_cnt !== 14) begin miscompares++; $display("FAIL basic_holdup_cycles: got %0d want 14", holdup_cnt); end
    vectors++; if (read_seen !== 0) begin miscompares++; $display("FAIL basic_cmd_read: got %0d want 0", read_seen); end
  endtask

  task automatic test_stall();
    int t; bit ok, got;
    logic [31:0] a;
    logic [67:0] w;
    fill_elems(1'b0);
    a = $urandom & 32'hFFFF_FFFC;
    start_txn(a, 2'd1, 3, 1, -1, t, ok);
    wait_eai(got);
    vectors++; if ({ok, got} !== 2'b11) begin miscompares++; $display("FAIL stall_done: got %b want 11", {ok, got}); end
    vectors++; if (cmd_log.size() !== NW) begin miscompares++; $display("FAIL stall_nwrites: got %0d want %0d", cmd_log.size(), NW); end
    for (int k = 0; k < NW; k++) begin
      w = (k < cmd_log.size()) ? {cmd_log[k].addr, cmd_log[k].wdata, cmd_log[k].mask} : 'x;
      vectors++; if (w !== exp_word(a, k)) begin miscompares++;
        $display("FAIL stall_word%0d: got %h want %h", k, w, exp_word(a, k)); end
    end
    vectors++; if (max_pend > 2) begin miscompares++; $display("FAIL stall_outstanding: got %0d want <=2", max_pend); end
    vectors++; if (stall_changes !== 0) begin miscompares++; $display("FAIL stall_stable: got %0d changes want 0", stall_changes); end
    if (got) begin
      vectors++; if ({eai_log[0].wdat, eai_log[0].err} !== {a, 1'b0}) begin miscompares++;
        $display("FAIL stall_eai: got %h/%b want %h/0", eai_log[0].wdat, eai_log[0].err, a); end
    end
  endtask

  task automatic test_err();
    int t; bit ok, got;
    fill_elems(1'b0);
    start_txn(32'h2000, 2'd3, 1, 0, 5, t, ok);
    wait_eai(got);
    vectors++; if ({ok, got} !== 2'b11) begin miscompares++; $display("FAIL err_done: got %b want 11", {ok, got}); end
    vectors++; if (cmd_log.size() !== NW) begin miscompares++; $display("FAIL err_nwrites: got %0d want %0d", cmd_log.size(), NW); end
    if (cmd_log.size() == NW) begin
      vectors++; if ({cmd_log[12].addr, cmd_log[12].wdata, cmd_log[12].mask} !== exp_word(32'h2000, 12)) begin miscompares++;
        $display("FAIL err_last_word: got %h want %h", {cmd_log[12].addr, cmd_log[12].wdata, cmd_log[12].mask}, exp_word(32'h2000, 12)); end
    end
    if (got) begin
      vectors++; if ({eai_log[0].itag, eai_log[0].err} !== {2'd3, 1'b1}) begin miscompares++;
        $display("FAIL err_eai_err: got %0d/%b want 3/1", eai_log[0].itag, eai_log[0].err); end
    end
  endtask

  task automatic test_misaligned();
    int t; bit ok, got;
    fill_elems(1'b0);
    start_txn(32'h1002, 2'd1, 1, 0, -1, t, ok);
    wait_eai(got);
    vectors++; if ({ok, got} !== 2'b11) begin miscompares++; $display("FAIL mis_done: got %b want 11", {ok, got}); end
    vectors++; if (cmdv_cnt !== 0) begin miscompares++; $display("FAIL mis_no_cmd: got %0d valid cycles want 0", cmdv_cnt); end
    vectors++; if (holdup_cnt !== 0) begin miscompares++; $display("FAIL mis_holdup: got %0d want 0", holdup_cnt); end
    if (got) begin
      vectors++; if (eai_log[0].cyc_no - t !== 1) begin miscompares++;
        $display("FAIL mis_latency: got %0d want 1", eai_log[0].cyc_no - t); end
      vectors++; if ({eai_log[0].wdat, eai_log[0].err} !== {32'h1002, 1'b1}) begin miscompares++;
        $display("FAIL mis_eai: got %h/%b want 00001002/1", eai_log[0].wdat, eai_log[0].err); end
    end
  endtask

  task automatic test_reset_mid();
    int t; bit ok, got, six;
    logic [31:0] a;
    logic [67:0] w;
    fill_elems(1'b0);
    start_txn(32'h3000, 2'd0, 2, 0, -1, t, ok);
    six = 1'b0;
    for (int i = 0; i < 60 && !six; i++) begin
      @(negedge clk);
      six = cmd_log.size() >= 6;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++; if ({ok, six} !== 2'b11) begin miscompares++; $display("FAIL rmid_started: got %b want 11", {ok, six}); end
    vectors++; if ({icb.eai_icb_cmd_valid, eai_mem_holdup, res_ready} !== 3'b001) begin miscompares++;
      $display("FAIL rmid_after_rst: got %b want 001", {icb.eai_icb_cmd_valid, eai_mem_holdup, res_ready}); end
    rst = 1'b0;
    for (int i = 0; i < 50 && pend.size() > 0; i++) @(negedge clk);
    repeat (10) @(posedge clk);
    #1;
    vectors++; if (eai_log.size() !== 0) begin miscompares++; $display("FAIL rmid_no_eai: got %0d responses want 0", eai_log.size()); end
    fill_elems(1'b0);
    a = $urandom & 32'hFFFF_FFFC;
    start_txn(a, 2'd1, 1, 0, -1, t, ok);
    wait_eai(got);
    vectors++; if ({ok, got, cmd_log.size() == NW} !== 3'b111) begin miscompares++;
      $display("FAIL rmid_fresh_done: got %b nwrites %0d want 111", {ok, got}, cmd_log.size()); end
    for (int k = 0; k < NW; k++) begin
      w = (k < cmd_log.size()) ? {cmd_log[k].addr, cmd_log[k].wdata, cmd_log[k].mask} : 'x;
      vectors++; if (w !== exp_word(a, k)) begin miscompares++;
        $display("FAIL rmid_word%0d: got %h want %h", k, w, exp_word(a, k)); end
    end
    if (got) begin
      vectors++; if ({eai_log[0].cyc_no - t, eai_log[0].wdat, eai_log[0].err} !== {32'd15, a, 1'b0}) begin miscompares++;
        $display("FAIL rmid_fresh_eai: got lat %0d %h/%b want 15 %h/0", eai_log[0].cyc_no - t, eai_log[0].wdat, eai_log[0].err, a); end
    end
  endtask

  task automatic test_backpressure();
    int t; bit ok, seen;
    logic [31:0] a;
    fill_elems(1'b0);
    a = $urandom & 32'hFFFF_FFFC;
    eai_rsp_ready = 1'b0;
    start_txn(a, 2'd3, 1, 0, -1, t, ok);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = eai_rsp_valid;
    end
    vectors++; if ({ok, seen} !== 2'b11) begin miscompares++; $display("FAIL bp_valid_seen: got %b want 11", {ok, seen}); end
    for (int c = 0; c < 4; c++) begin
      vectors++; if ({eai_rsp_valid, eai_rsp_wdat, eai_rsp_itag, eai_rsp_err, res_ready} !== {1'b1, a, 2'd3, 1'b0, 1'b0}) begin
        miscompares++; $display("FAIL bp_hold%0d: got %b/%h/%0d/%b rdy %b want 1/%h/3/0 rdy 0", c,
          eai_rsp_valid, eai_rsp_wdat, eai_rsp_itag, eai_rsp_err, res_ready, a); end
      @(negedge clk);
    end
    @(posedge clk); #1;
    eai_rsp_ready = 1'b1;
    @(posedge clk); #1;
    vectors++; if ({eai_log.size() == 1, res_ready, eai_rsp_valid} !== 3'b110) begin miscompares++;
      $display("FAIL bp_release: got %b want 110", {eai_log.size() == 1, res_ready, eai_rsp_valid}); end
    vectors++; if (eai_unstable !== 0) begin miscompares++; $display("FAIL bp_stable: got %0d changes want 0", eai_unstable); end
  endtask

  task automatic test_random();
    int t; bit ok, got;
    logic [31:0] a;
    logic [IW-1:0] tag;
    logic [67:0] w;
    int errw, r, nexp;
    bit mis;
    for (int n = 0; n < 8; n++) begin
      fill_elems(1'b0);
      mis = ($urandom_range(0, 4) == 0);
      a = $urandom;
      a[1:0] = mis ? 2'($urandom_range(1, 3)) : 2'b00;
      tag = IW'($urandom);
      r = $urandom_range(0, 19);
      errw = (r < NW) ? r : -1;
      start_txn(a, tag, $urandom_range(1, 4), 2, errw, t, ok);
      wait_eai(got);
      nexp = mis ? 0 : NW;
      vectors++; if ({ok, got} !== 2'b11 || cmd_log.size() !== nexp) begin miscompares++;
        $display("FAIL rnd%0d_done: got %b nwrites %0d want 11 nwrites %0d", n, {ok, got}, cmd_log.size(), nexp); end
      for (int k = 0; k < nexp; k++) begin
        w = (k < cmd_log.size()) ? {cmd_log[k].addr, cmd_log[k].wdata, cmd_log[k].mask} : 'x;
        vectors++; if (w !== exp_word(a, k)) begin miscompares++;
          $display("FAIL rnd%0d_word%0d: got %h want %h", n, k, w, exp_word(a, k)); end
      end
      if (got) begin
        vectors++; if ({eai_log[0].wdat, eai_log[0].itag, eai_log[0].err} !== {a, tag, mis || errw >= 0}) begin miscompares++;
          $display("FAIL rnd%0d_eai: got %h/%0d/%b want %h/%0d/%b", n, eai_log[0].wdat, eai_log[0].itag,
            eai_log[0].err, a, tag, mis || errw >= 0); end
      end
      vectors++; if (max_pend > 2 || stall_changes !== 0) begin miscompares++;
        $display("FAIL rnd%0d_bus: outstanding %0d changes %0d want <=2 and 0", n, max_pend, stall_changes); end
    end
  endtask

  initial begin
    rst = 1'b1; res_valid = 1'b0; res_y = '0; res_addr = '0; res_itag = '0; eai_rsp_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_err();
    test_misaligned();
    test_reset_mid();
    test_backpressure();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cnn_result_wb.md
CNN_RESULT_WB -- requirements
Module: cnn_result_wb

Interface
REQ-001 The block SHALL have parameters (name, default, meaning): DATA_WIDTH, 32, ICB data/address width.
REQ-002 The block SHALL have parameter DISP_ITAG_WIDTH, 2, EAI instruction tag width.
REQ-003 The block SHALL have parameter ELEM_NUM, 25, number of 16-bit results (5x5 conv output).
REQ-004 The block SHALL have parameter OUTS_MAX, 2, maximum outstanding ICB write commands.
REQ-005 The block SHALL have these ports: clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 res_valid  in  1  conv result and write request present.
REQ-008 res_ready  out  1  result accepted.
REQ-009 res_y  in  ELEM_NUM*16  packed results; element n is res_y[16n+15:16n].
REQ-010 res_addr  in  DATA_WIDTH  destination base byte address.
REQ-011 res_itag  in  DISP_ITAG_WIDTH  tag returned with the EAI response.
REQ-012 eai_icb_cmd_valid/ready, eai_icb_cmd_addr (DATA_WIDTH), eai_icb_cmd_read (1), eai_icb_cmd_wdata (DATA_WIDTH), eai_icb_cmd_wmask (4)  out/in/out/out/out/out  ICB command channel.
REQ-013 eai_icb_rsp_valid/ready/err  in/out/in  1 each  ICB response channel; rdata is not used.
REQ-014 eai_rsp_valid/ready, eai_rsp_wdat (DATA_WIDTH), eai_rsp_itag (DISP_ITAG_WIDTH), eai_rsp_err (1)  out/in/out/out/out  EAI response to core.
REQ-015 eai_mem_holdup  out  1  high while this block owns the memory port.

Function
REQ-016 The FSM SHALL have states IDLE, WRITE, RESP.
REQ-017 In IDLE, res_ready SHALL be 1, and a res_valid&res_ready cycle SHALL capture res_y, res_addr and res_itag into registers.
REQ-018 Capture SHALL transition to WRITE if res_addr[1:0]==0, else to RESP with sticky err=1 and no ICB commands issued.
REQ-019 Words SHALL be packed as follows: word k (0..12) at res_addr+4k, wdata = {elem 2k+1, elem 2k}, wmask 4'b1111; word 12 SHALL have wdata = {16'b0, elem 24} and wmask 4'b0011.
REQ-020 eai_icb_cmd_read SHALL be constantly 0.
REQ-021 A command counter (0..13) SHALL advance on each cmd_valid&cmd_ready, and a response counter (0..13) SHALL advance on each rsp_valid&rsp_ready.
REQ-022 eai_icb_cmd_valid SHALL be 1 in WRITE only while cmd_cnt<13 and (cmd_cnt-rsp_cnt)<OUTS_MAX; addr, wdata and wmask SHALL be stable while valid&!ready.
REQ-023 eai_icb_rsp_ready SHALL be 1 whenever rst=0; responses received in IDLE or RESP SHALL be discarded.
REQ-024 Any accepted rsp with err=1 in WRITE SHALL set the sticky err flag; remaining writes SHALL still be issued.
REQ-025 A cycle with simultaneous cmd handshake and rsp handshake SHALL update both counters, leaving outstanding count unchanged.
REQ-026 WRITE SHALL transition to RESP on the cycle rsp_cnt reaches 13.
REQ-027 In RESP, eai_rsp_valid SHALL be 1 with wdat=captured res_addr, itag=captured itag, err=sticky err; it SHALL hold until eai_rsp_ready, then transition to IDLE and clear err and both counters.
REQ-028 eai_mem_holdup SHALL be 1 exactly while the state is WRITE.
REQ-029 Latency SHALL be as follows: with cmd_ready=1 and rsp one cycle after cmd, capture at cycle T gives first cmd at T+1, last cmd at T+13, last rsp at T+14, and eai_rsp_valid at T+15.

Reset
REQ-030 When rst=1 at a clock edge, the state SHALL become IDLE, counters and err SHALL clear, and captured registers SHALL be zeroed.
REQ-031 Output reset values SHALL be: res_ready=1 after the reset cycle, cmd_valid=0, rsp_ready=1 once rst=0, eai_rsp_valid=0, wdat=0, itag=0, err=0, holdup=0.
REQ-032 Reset asserted mid-WRITE SHALL abandon the transfer with no EAI response generated, and later stale ICB responses SHALL be dropped.

Structure
REQ-033 DATA_WIDTH, DISP_ITAG_WIDTH, ELEM_NUM, the word count (13) and the state encodings SHALL reside in the shared define.v.
REQ-034 The block SHALL contain one natural sub-module, cnn_wb_pack, which is combinational and maps (res_y, k) to (wdata, wmask).

Verification
REQ-035 Verification SHALL cover this scenario: addr=0x1000, elem n=n+1, always-ready bus -> 13 writes at 0x1000..0x1030, word0=0x00020001, word12=0x00000019 with mask 0011, eai_rsp at T+15 with wdat=0x1000 and err=0.
REQ-036 Verification SHALL cover this scenario: cmd_ready toggling 1/0 and rsp delayed 3 cycles -> outstanding never exceeds 2, command fields stable while stalled, all 13 writes correct.
REQ-037 Verification SHALL cover this scenario: rsp err=1 on word 5 -> all 13 writes still issued, and eai_rsp_err=1.
REQ-038 Verification SHALL cover this scenario: addr=0x1002 -> no cmd_valid, eai_rsp_valid at T+1 with err=1, and holdup stays 0.
REQ-039 Verification SHALL cover this scenario: rst pulsed after 6 writes -> cmd_valid=0 on the next cycle, no eai_rsp, and a fresh request then completes normally.
REQ-040 Verification SHALL cover this scenario: eai_rsp_ready held 0 for 4 cycles -> rsp fields stable, res_ready=0, and IDLE is entered only after the handshake.
